// File: rtl/scan_controller.sv
// Moore FSM sequencing a row/column scan over an 8x8 address space through an
// external pair of 3-bit load/increment counters, one memory read per address.
module scan_controller #(
  parameter logic [2:0] COL_INIT = 3'd0,
  parameter logic [2:0] ROW_INIT = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       mem_ready_i,
  input  logic       col_carry_i,
  input  logic       row_carry_i,
  output logic       col_ld_o,
  output logic       col_inc_o,
  output logic       row_ld_o,
  output logic       row_inc_o,
  output logic [2:0] col_init_o,
  output logic [2:0] row_init_o,
  output logic       rd_en_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_INC_COL,
    S_CHK_COL,
    S_INC_ROW,
    S_CHK_ROW,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  assign col_init_o = COL_INIT;
  assign row_init_o = ROW_INIT;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Carries are only trusted in the CHK states, one cycle after the matching inc.
  always_comb begin
    state_d   = state_q;
    col_ld_o  = 1'b0;
    col_inc_o = 1'b0;
    row_ld_o  = 1'b0;
    row_inc_o = 1'b0;
    rd_en_o   = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        col_ld_o = 1'b1;
        row_ld_o = 1'b1;
        state_d  = S_REQ;
      end
      S_REQ: begin
        rd_en_o = 1'b1;
        if (mem_ready_i) state_d = S_INC_COL;
      end
      S_INC_COL: begin
        col_inc_o = 1'b1;
        state_d   = S_CHK_COL;
      end
      S_CHK_COL: begin
        state_d = col_carry_i ? S_INC_ROW : S_REQ;
      end
      S_INC_ROW: begin
        row_inc_o = 1'b1;
        col_ld_o  = 1'b1;
        state_d   = S_CHK_ROW;
      end
      S_CHK_ROW: begin
        state_d = row_carry_i ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: two instances (default and COL_INIT=5/ROW_INIT=6)
// each driving a behavioural counter pair, checked against an address-list model.
module tb_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start, mem_ready;
  logic       force_cc;
  logic [1:0] col_ld, col_inc, row_ld, row_inc, rd_en, busy, done;
  logic [2:0] col_init [2];
  logic [2:0] row_init [2];
  logic [2:0] col_cnt [2];
  logic [2:0] row_cnt [2];
  logic [1:0] col_cy, row_cy, cc_in, rc_in;

  int vectors = 0;
  int miscompares = 0;
  int plan [2][64];
  int rd_idx [2], wcnt [2], hs_cnt [2], ci_cnt [2], ri_cnt [2], dn_cnt [2], busy_cnt [2], dcyc [2];
  int n;
  bit mon_en;
  logic [5:0] q0 [$];
  logic [5:0] q1 [$];

  always #5 clk = ~clk;

  // Stale carries are made visible to the DUT while it sits in REQ or IDLE.
  assign cc_in = col_cy | ({2{force_cc}} & (rd_en | ~busy));
  assign rc_in = row_cy | ({2{force_cc}} & (rd_en | ~busy));

  scan_controller u_dut0 (
    .clk(clk), .reset(reset), .start_i(start[0]), .mem_ready_i(mem_ready[0]),
    .col_carry_i(cc_in[0]), .row_carry_i(rc_in[0]),
    .col_ld_o(col_ld[0]), .col_inc_o(col_inc[0]), .row_ld_o(row_ld[0]), .row_inc_o(row_inc[0]),
    .col_init_o(col_init[0]), .row_init_o(row_init[0]),
    .rd_en_o(rd_en[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  scan_controller #(.COL_INIT(3'd5), .ROW_INIT(3'd6)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start[1]), .mem_ready_i(mem_ready[1]),
    .col_carry_i(cc_in[1]), .row_carry_i(rc_in[1]),
    .col_ld_o(col_ld[1]), .col_inc_o(col_inc[1]), .row_ld_o(row_ld[1]), .row_inc_o(row_inc[1]),
    .col_init_o(col_init[1]), .row_init_o(row_init[1]),
    .rd_en_o(rd_en[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  // External load/increment counters with registered carry.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (col_ld[k]) begin
        col_cnt[k] <= col_init[k];
        col_cy[k]  <= 1'b0;
      end else if (col_inc[k]) begin
        col_cnt[k] <= col_cnt[k] + 3'd1;
        col_cy[k]  <= (col_cnt[k] == 3'd7);
      end
      if (row_ld[k]) begin
        row_cnt[k] <= row_init[k];
        row_cy[k]  <= 1'b0;
      end else if (row_inc[k]) begin
        row_cnt[k] <= row_cnt[k] + 3'd1;
        row_cy[k]  <= (row_cnt[k] == 3'd7);
      end
    end
  end

  function automatic int ci(input int k);
    return (k == 0) ? 0 : 5;
  endfunction

  function automatic int ri(input int k);
    return (k == 0) ? 0 : 6;
  endfunction

  function automatic logic [6:0] outs(input int k);
    return {col_ld[k], col_inc[k], row_ld[k], row_inc[k], rd_en[k], busy[k], done[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_addr(input int k);
    logic [5:0] e;
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    chk($sformatf("read_expected%0d", k), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("addr%0d", k), 32'({row_cnt[k], col_cnt[k]}), 32'(e));
    end
  endtask

  task automatic cycle();
    logic [1:0] hs, stall;
    for (int k = 0; k < 2; k++) begin
      hs[k]    = mon_en && rd_en[k] && mem_ready[k];
      stall[k] = mon_en && rd_en[k] && !mem_ready[k] && !reset;
      if (hs[k]) begin
        hs_cnt[k]++;
        check_addr(k);
      end
    end
    @(posedge clk);
    #1;
    force_cc = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      if (hs[k]) begin
        rd_idx[k]++;
        wcnt[k] = 0;
      end
      if (rd_en[k] === 1'b1) begin
        mem_ready[k] = (wcnt[k] >= ((rd_idx[k] < 64) ? plan[k][rd_idx[k]] : 0));
        wcnt[k]++;
      end else begin
        mem_ready[k] = 1'($urandom);
      end
      if (mon_en) begin
        if (stall[k]) chk($sformatf("rd_hold%0d", k), 32'(rd_en[k]), 32'd1);
        chk($sformatf("excl%0d", k), 32'(32'(col_inc[k]) + 32'(row_inc[k]) + 32'(rd_en[k]) <= 1), 32'd1);
        chk($sformatf("ld_pair%0d", k),
            32'((col_ld[k] & ~(row_ld[k] | row_inc[k])) | (row_ld[k] & ~col_ld[k])), 32'd0);
        ci_cnt[k]   += 32'(col_inc[k]);
        ri_cnt[k]   += 32'(row_inc[k]);
        dn_cnt[k]   += 32'(done[k]);
        busy_cnt[k] += 32'(busy[k]);
      end
    end
  endtask

  task automatic set_plan(input int k, input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       plan[k][i] = 0;
        1:       plan[k][i] = (i % 3 == 2) ? 4 : 0;
        default: plan[k][i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      endcase
    end
  endtask

  task automatic begin_scan(input logic [1:0] m);
    for (int k = 0; k < 2; k++) begin
      if (m[k]) begin
        if (k == 0) q0.delete(); else q1.delete();
        for (int r = ri(k); r < 8; r++)
          for (int c = ci(k); c < 8; c++)
            if (k == 0) q0.push_back(6'(r * 8 + c)); else q1.push_back(6'(r * 8 + c));
        hs_cnt[k] = 0; ci_cnt[k] = 0; ri_cnt[k] = 0; dn_cnt[k] = 0; busy_cnt[k] = 0;
        rd_idx[k] = 0; wcnt[k] = 0; dcyc[k] = -1;
        start[k] = 1'b1;
      end
    end
    cycle();
    start = 2'b00;
    n = 1;
    for (int k = 0; k < 2; k++)
      if (m[k]) chk($sformatf("load_outs%0d", k), 32'(outs(k)), 32'b1010010);
  endtask

  task automatic run_until_done(input logic [1:0] m, input bit dir);
    bit fin;
    forever begin
      fin = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (m[k] && done[k] && dcyc[k] < 0) dcyc[k] = n;
        if (m[k] && dcyc[k] < 0) fin = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (m[k] && (dcyc[k] < 0 || dcyc[k] == n))
          start[k] = dir ? (k == 0 && (n == 50 || n == 210)) : ($urandom_range(0, 3) == 0);
        else
          start[k] = 1'b0;
      end
      cycle();
      n++;
      if (fin) begin
        start = 2'b00;
        break;
      end
      if (n > 3000) begin
        chk("done_timeout", 32'(fin), 32'd1);
        start = 2'b00;
        break;
      end
    end
  endtask

  task automatic finish_scan(input logic [1:0] m);
    int nr, nrow, sum, exp_done;
    for (int k = 0; k < 2; k++) begin
      if (m[k]) begin
        nrow = 8 - ri(k);
        nr   = (8 - ci(k)) * nrow;
        sum  = 0;
        for (int i = 0; i < nr; i++) sum += plan[k][i];
        exp_done = 1 + 3 * nr + sum + 2 * nrow + 1;
        chk($sformatf("done_cycle%0d", k), 32'(dcyc[k]), 32'(exp_done));
        chk($sformatf("busy_cycles%0d", k), 32'(busy_cnt[k]), 32'(exp_done));
        chk($sformatf("busy_after%0d", k), 32'(busy[k]), 32'd0);
        chk($sformatf("handshakes%0d", k), 32'(hs_cnt[k]), 32'(nr));
        chk($sformatf("col_incs%0d", k), 32'(ci_cnt[k]), 32'(nr));
        chk($sformatf("row_incs%0d", k), 32'(ri_cnt[k]), 32'(nrow));
        chk($sformatf("done_pulses%0d", k), 32'(dn_cnt[k]), 32'd1);
        chk($sformatf("reads_left%0d", k), 32'((k == 0) ? q0.size() : q1.size()), 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 2'b00; mem_ready = 2'b00; force_cc = 1'b0; mon_en = 1'b0; n = 0;
    for (int k = 0; k < 2; k++) begin
      hs_cnt[k] = 0; ci_cnt[k] = 0; ri_cnt[k] = 0; dn_cnt[k] = 0; busy_cnt[k] = 0;
      rd_idx[k] = 0; wcnt[k] = 0; dcyc[k] = -1;
      set_plan(k, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_outs%0d", k), 32'(outs(k)), 32'd0);
      chk($sformatf("col_init%0d", k), 32'(col_init[k]), 32'(ci(k)));
      chk($sformatf("row_init%0d", k), 32'(row_init[k]), 32'(ri(k)));
    end
    reset  = 1'b0;
    mon_en = 1'b1;

    // Both instances, mem_ready tied high; start re-pulsed at cycles 50 and 210.
    begin_scan(2'b11);
    run_until_done(2'b11, 1'b1);
    finish_scan(2'b11);

    // Back-to-back: start in the first idle cycle, then 4-cycle stalls every third read.
    chk("idle_after_done", 32'(busy[0]), 32'd0);
    set_plan(0, 1);
    begin_scan(2'b01);
    run_until_done(2'b01, 1'b0);
    finish_scan(2'b01);

    // Reset in cycle 100 aborts the scan without a done pulse.
    set_plan(0, 2);
    begin_scan(2'b01);
    while (n < 100) begin
      cycle();
      n++;
    end
    reset = 1'b1;
    cycle();
    chk("abort_outs0", 32'(outs(0)), 32'd0);
    chk("abort_outs1", 32'(outs(1)), 32'd0);
    chk("abort_col_init0", 32'(col_init[0]), 32'd0);
    reset = 1'b0;
    repeat (3) cycle();
    chk("abort_no_done", 32'(dn_cnt[0]), 32'd0);
    chk("abort_idle", 32'(busy[0]), 32'd0);

    // Full scan after the abort, then randomized stalls, start noise and stale carries.
    set_plan(0, 0);
    set_plan(1, 0);
    begin_scan(2'b11);
    run_until_done(2'b11, 1'b0);
    finish_scan(2'b11);
    repeat (3) begin
      set_plan(0, 2);
      set_plan(1, 2);
      begin_scan(2'b11);
      run_until_done(2'b11, 1'b0);
      finish_scan(2'b11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
